// File: rtl/muldiv_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared definitions for the RV32M multiply/divide sequencer: operand width,
// iteration counter width, the ALU function codes of the M extension, the
// sequencer state type and small decode helpers used by both the control
// FSM and the iterative datapath.
// ---------------------------------------------------------------------------
package muldiv_sequencer_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   // M-extension function codes as produced by ALU control; they form one
   // contiguous range so membership is a simple range compare.
   localparam logic [4:0] ALU_MUL    = 5'd16;
   localparam logic [4:0] ALU_MULH   = 5'd17;
   localparam logic [4:0] ALU_MULHSU = 5'd18;
   localparam logic [4:0] ALU_MULHU  = 5'd19;
   localparam logic [4:0] ALU_DIV    = 5'd20;
   localparam logic [4:0] ALU_DIVU   = 5'd21;
   localparam logic [4:0] ALU_REM    = 5'd22;
   localparam logic [4:0] ALU_REMU   = 5'd23;

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_CALC = 2'd1,
      STATE_DONE = 2'd2
   } seqState_t;

   // True for any function this sequencer handles.
   function automatic logic isMulDiv(input logic [4:0] func);
      return (func >= ALU_MUL) && (func <= ALU_REMU);
   endfunction

   // True for DIV/DIVU/REM/REMU.
   function automatic logic isDivide(input logic [4:0] func);
      return (func >= ALU_DIV) && (func <= ALU_REMU);
   endfunction

   // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
   function automatic logic operandASigned(input logic [4:0] func);
      return (func == ALU_MUL) || (func == ALU_MULH) || (func == ALU_MULHSU) ||
             (func == ALU_DIV) || (func == ALU_REM);
   endfunction

   // rs2 is signed only for MUL, MULH, DIV and REM (MULHSU takes it unsigned).
   function automatic logic operandBSigned(input logic [4:0] func);
      return (func == ALU_MUL) || (func == ALU_MULH) ||
             (func == ALU_DIV) || (func == ALU_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// ---------------------------------------------------------------------------
// muldiv_iter_datapath
// Iterative shift-add multiplier / restoring divider working on operand
// magnitudes, with sign fix-up on the way out.
//   clock       in   core clock
//   reset       in   synchronous active-high reset
//   load        in   capture function code, signs and magnitudes of operands
//   step        in   perform one multiply or divide iteration
//   aluFunction in   M-extension function code (sampled on load)
//   operandA    in   rs1 value (sampled on load)
//   operandB    in   rs2 value (sampled on load)
//   resultNext  out  signed/selected result as it will be after this step
// ---------------------------------------------------------------------------
module muldiv_iter_datapath
   import muldiv_sequencer_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  logic [4:0]      aluFunction,
   input  logic [XLEN-1:0] operandA,
   input  logic [XLEN-1:0] operandB,
   output logic [XLEN-1:0] resultNext
);

   logic [4:0]        funcReg;
   logic              negA;
   logic              negB;
   logic [XLEN-1:0]   factorReg;
   logic [2*XLEN-1:0] workReg;

   logic              loadNegA;
   logic              loadNegB;
   logic [XLEN-1:0]   magA;
   logic [XLEN-1:0]   magB;

   logic [XLEN:0]     mulSum;
   logic [2*XLEN-1:0] mulNext;
   logic [XLEN:0]     remShift;
   logic [XLEN:0]     trialDiff;
   logic              quoBit;
   logic [XLEN-1:0]   remNew;
   logic [2*XLEN-1:0] divNext;
   logic [2*XLEN-1:0] stepped;
   logic [2*XLEN-1:0] productFinal;
   logic [XLEN-1:0]   quoFinal;
   logic [XLEN-1:0]   remFinal;

   // Operand preparation: an operand counts as negative only when its
   // function treats it as signed and its top bit is set; the iteration
   // itself always runs on unsigned magnitudes.
   always_comb begin
      loadNegA = operandASigned(aluFunction) & operandA[XLEN-1];
      loadNegB = operandBSigned(aluFunction) & operandB[XLEN-1];
      magA     = loadNegA ? -operandA : operandA;
      magB     = loadNegB ? -operandB : operandB;
   end

   // One iteration of either algorithm, sharing the same 2*XLEN work
   // register. Multiply keeps {partial product, multiplier} and shifts right,
   // adding the multiplicand when the low multiplier bit is set. Divide keeps
   // {remainder, dividend/quotient} and shifts left, trying a subtract of the
   // divisor; because the remainder is always below the divisor, the trial
   // difference fits in XLEN+1 bits and its top bit is the borrow.
   always_comb begin
      mulSum    = {1'b0, workReg[2*XLEN-1:XLEN]} +
                  {1'b0, (workReg[0] ? factorReg : {XLEN{1'b0}})};
      mulNext   = {mulSum, workReg[XLEN-1:1]};
      remShift  = {workReg[2*XLEN-1:XLEN], workReg[XLEN-1]};
      trialDiff = remShift - {1'b0, factorReg};
      quoBit    = ~trialDiff[XLEN];
      remNew    = quoBit ? trialDiff[XLEN-1:0] : remShift[XLEN-1:0];
      divNext   = {remNew, workReg[XLEN-2:0], quoBit};
      stepped   = isDivide(funcReg) ? divNext : mulNext;
   end

   // Sign fix-up and result selection computed from the post-step value so
   // the controller can register the final answer on the same edge as the
   // last iteration. The remainder follows the dividend's sign.
   always_comb begin
      productFinal = (negA ^ negB) ? -stepped : stepped;
      quoFinal     = (negA ^ negB) ? -stepped[XLEN-1:0] : stepped[XLEN-1:0];
      remFinal     = negA ? -stepped[2*XLEN-1:XLEN] : stepped[2*XLEN-1:XLEN];
      case (funcReg)
         ALU_MUL:                        resultNext = productFinal[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: resultNext = productFinal[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:              resultNext = quoFinal;
         default:                        resultNext = remFinal;
      endcase
   end

   // Load captures the operation and magnitudes; the low half of the work
   // register starts as the multiplier or the dividend.
   always_ff @(posedge clock) begin
      if (reset) begin
         funcReg   <= 5'd0;
         negA      <= 1'b0;
         negB      <= 1'b0;
         factorReg <= '0;
         workReg   <= '0;
      end else if (load) begin
         funcReg   <= aluFunction;
         negA      <= loadNegA;
         negB      <= loadNegB;
         factorReg <= magB;
         workReg   <= {{XLEN{1'b0}}, magA};
      end else if (step) begin
         workReg   <= stepped;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle controller for RV32M. Accepts an M-extension op from EX,
// stalls the core for the 32 iterations of the datapath (or one cycle for
// divide-by-zero / signed overflow), then pulses done with the result.
//   clock        in   core clock
//   reset        in   synchronous active-high reset
//   start        in   EX holds an M op; kept high while stall is high
//   flush        in   synchronous abort, wins over start
//   alu_function in   function code, sampled on accept
//   operand_a    in   rs1, sampled on accept
//   operand_b    in   rs2, sampled on accept
//   stall        out  hold PC/IF/ID/EX
//   done         out  one-cycle result-valid pulse
//   result       out  last result, held until the next completion
// ---------------------------------------------------------------------------
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [4:0]      alu_function,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   seqState_t        state;
   logic [CNT_W-1:0] counter;
   logic             accept;
   logic             divByZero;
   logic             divOverflow;
   logic             special;
   logic [XLEN-1:0]  specialValue;
   logic             lastStep;
   logic [XLEN-1:0]  dpResult;

   // Accept and stall decode. Reset and flush suppress acceptance so an
   // aborted cycle never starts an operation. Stall drops in DONE so the
   // retiring instruction leaves EX that very cycle.
   always_comb begin
      accept   = (state == STATE_IDLE) && start && isMulDiv(alu_function) &&
                 !flush && !reset;
      stall    = accept || (state == STATE_CALC);
      lastStep = (state == STATE_CALC) && (counter == CNT_W'(XLEN - 1));
   end

   // Cases whose answer is fixed by the ISA and skip iteration entirely:
   // divide by zero gives all ones / the dividend, and the signed overflow
   // case gives the most negative value / zero.
   always_comb begin
      divByZero    = isDivide(alu_function) && (operand_b == '0);
      divOverflow  = ((alu_function == ALU_DIV) || (alu_function == ALU_REM)) &&
                     (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (operand_b == {XLEN{1'b1}});
      special      = divByZero || divOverflow;
      specialValue = operand_a;
      if (divByZero) begin
         if ((alu_function == ALU_DIV) || (alu_function == ALU_DIVU))
            specialValue = {XLEN{1'b1}};
      end else if (alu_function == ALU_REM) begin
         specialValue = '0;
      end
   end

   muldiv_iter_datapath datapath (
      .clock       (clock),
      .reset       (reset),
      .load        (accept),
      .step        (state == STATE_CALC),
      .aluFunction (alu_function),
      .operandA    (operand_a),
      .operandB    (operand_b),
      .resultNext  (dpResult)
   );

   // Sequencer FSM. The counter tracks completed iterations: the step taken
   // while it reads XLEN-1 is the last one, so the result is registered on
   // that edge and the counter comes to rest at XLEN. Result and done only
   // change on DONE entry; flush returns to IDLE leaving result untouched.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= STATE_IDLE;
         counter <= '0;
         result  <= '0;
         done    <= 1'b0;
      end else if (flush) begin
         state   <= STATE_IDLE;
         counter <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            STATE_IDLE: begin
               if (accept) begin
                  counter <= '0;
                  if (special) begin
                     state  <= STATE_DONE;
                     result <= specialValue;
                     done   <= 1'b1;
                  end else begin
                     state  <= STATE_CALC;
                  end
               end
            end
            STATE_CALC: begin
               if (counter != CNT_W'(XLEN))
                  counter <= counter + CNT_W'(1);
               if (lastStep) begin
                  state  <= STATE_DONE;
                  result <= dpResult;
                  done   <= 1'b1;
               end
            end
            STATE_DONE: begin
               state <= STATE_IDLE;
            end
            default: begin
               state <= STATE_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed scoreboard bench for muldiv_sequencer: the driver pushes the
// hand-computed result and due cycle of each op into a queue, and a monitor
// pops and compares whenever done pulses.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          due;
   } expT;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  aluFunction = 5'd0;
   logic [31:0] operandA = '0;
   logic [31:0] operandB = '0;
   logic        stall;
   logic        done;
   logic [31:0] result;

   expT         expQ[$];
   int          cycleCnt = 0;
   int          lastDoneCycle = 0;
   int          total = 0;
   int          bad = 0;
   logic [31:0] lastResult = '0;

   muldiv_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .flush        (flush),
      .alu_function (aluFunction),
      .operand_a    (operandA),
      .operand_b    (operandB),
      .stall        (stall),
      .done         (done),
      .result       (result)
   );

   // Free-running clock and cycle index used to time done against accept.
   always #5 clock = ~clock;

   always @(posedge clock) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   // both in value and in the cycle it arrives.
   always @(negedge clock) begin
      expT e;
      if (done === 1'b1) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected done: result 0x%08h with nothing outstanding", result);
         end else begin
            e = expQ.pop_front();
            checkOutput("result", result, e.res);
            checkOutput("done cycle", 32'(cycleCnt), 32'(e.due));
            lastDoneCycle = cycleCnt;
         end
      end
   end

   // Issue one op with start held until stall falls (the DONE cycle), then
   // leave it to the next call or idle to change start.
   task automatic applyStimulus(input logic [4:0] func, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expRes,
                                input int lat, output int issueCycle);
      int n;
      @(negedge clock);
      start       = 1'b1;
      aluFunction = func;
      operandA    = a;
      operandB    = b;
      issueCycle  = cycleCnt;
      expQ.push_back('{expRes, cycleCnt + lat});
      lastResult  = expRes;
      #1;
      n = 0;
      while (stall === 1'b1 && n < 200) begin
         n++;
         @(negedge clock);
         #1;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("[TB] FAIL stall timeout: func %0d still stalled after %0d cycles", func, n);
      end else begin
         checkOutput("stall cycles", 32'(n), 32'(lat));
      end
   endtask

   task automatic idle();
      @(negedge clock);
      start       = 1'b0;
      aluFunction = 5'd0;
   endtask

   initial begin
      int ic;
      int firstIssue;

      // Reset state.
      repeat (3) @(negedge clock);
      checkOutput("reset stall", 32'(stall), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset result", result, 32'd0);
      reset = 1'b0;

      // Non-M code is ignored.
      @(negedge clock);
      start = 1'b1;
      aluFunction = 5'd0;
      #1 checkOutput("non-M stall", 32'(stall), 32'd0);
      repeat (3) @(negedge clock);
      checkOutput("non-M stall later", 32'(stall), 32'd0);
      idle();

      // Multiplies.
      applyStimulus(ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, ic);
      applyStimulus(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, ic);
      applyStimulus(ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, ic);
      applyStimulus(ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, ic);
      applyStimulus(ALU_MUL,    32'h12345678, 32'h10,       32'h23456780, 33, ic);
      idle();

      // Divide special cases and normal divides.
      applyStimulus(ALU_DIVU, 32'd100,      32'd0,        32'hFFFFFFFF, 1,  ic);
      applyStimulus(ALU_REMU, 32'd100,      32'd0,        32'd100,      1,  ic);
      applyStimulus(ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  ic);
      applyStimulus(ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  ic);
      applyStimulus(ALU_REM,  32'd5,        32'd0,        32'd5,        1,  ic);
      applyStimulus(ALU_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, ic);
      applyStimulus(ALU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, ic);
      applyStimulus(ALU_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, ic);
      applyStimulus(ALU_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        33, ic);
      applyStimulus(ALU_DIVU, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 33, ic);
      applyStimulus(ALU_REMU, 32'hFFFFFFFF, 32'd16,       32'd15,       33, ic);
      idle();

      // Flush in the tenth CALC cycle: back to IDLE, no done, result kept.
      @(negedge clock);
      start = 1'b1;
      aluFunction = ALU_MUL;
      operandA = 32'd7;
      operandB = 32'd3;
      repeat (10) @(negedge clock);
      #1 checkOutput("stall before flush", 32'(stall), 32'd1);
      flush = 1'b1;
      start = 1'b0;
      @(negedge clock);
      flush = 1'b0;
      #1 checkOutput("stall after flush", 32'(stall), 32'd0);
      checkOutput("result after flush", result, lastResult);
      repeat (40) @(negedge clock);
      checkOutput("result long after flush", result, lastResult);

      // Flush wins over start in the same cycle.
      @(negedge clock);
      start = 1'b1;
      aluFunction = ALU_MUL;
      flush = 1'b1;
      #1 checkOutput("stall flush+start", 32'(stall), 32'd0);
      @(negedge clock);
      flush = 1'b0;
      start = 1'b0;
      #1 checkOutput("stall after flush+start", 32'(stall), 32'd0);
      repeat (40) @(negedge clock);

      // Back-to-back with start held: DONE does not re-accept the DIV.
      applyStimulus(ALU_DIV, 32'd100, 32'd7, 32'd14, 33, firstIssue);
      applyStimulus(ALU_MUL, 32'd6,   32'd7, 32'd42, 33, ic);
      checkOutput("back-to-back done cycle", 32'(lastDoneCycle - firstIssue), 32'd67);
      idle();
      repeat (40) @(negedge clock);

      checkOutput("outstanding expectations", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
